hazard_forward_ctrl: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage RV32I pipeline (IF/ID/EX/ME/WB).

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_forward_ctrl_src_match.sv | 21 ++
 rtl/hazard_forward_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard/forwarding controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BUBBLE   = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_ME = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

endpackage

// File: rtl/hazard_forward_ctrl_src_match.sv
// Compares one ID source register against the EX and ME destinations.
module src_match #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              RUWr_ex,
    input  logic [REG_AW-1:0] rd_me,
    input  logic              RUWr_me,
    output logic              match_ex,
    output logic              match_me
);

    // x0 is hardwired to zero, so a write to it never produces a dependency
    always_comb begin
        match_ex = rs_used && RUWr_ex && (rd_ex != '0) && (rd_ex == rs);
        match_me = rs_used && RUWr_me && (rd_me != '0) && (rd_me == rs);
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection, stall/flush generation and registered EX forward selects
// for a 5-stage RV32I pipeline, with saturating bubble/mem-wait counters.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int FWD_EN  = 1,
    parameter int COUNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] rs_id,
    input  logic [NUM_SRC-1:0]        rs_used_id,
    input  logic [REG_AW-1:0]         rd_ex,
    input  logic                      RUWr_ex,
    input  logic                      is_load_ex,
    input  logic [REG_AW-1:0]         rd_me,
    input  logic                      RUWr_me,
    input  logic                      mem_req_me,
    input  logic                      dmem_ack,
    output logic [NUM_SRC*2-1:0]      fwd_sel_ex,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      flush_ex,
    output logic                      stall_all,
    output logic [1:0]                hz_state,
    output logic [COUNT_W-1:0]        cnt_bubble,
    output logic [COUNT_W-1:0]        cnt_memwait
);

    localparam bit FWD_ON = (FWD_EN != 0);

    logic [NUM_SRC-1:0]   match_ex;
    logic [NUM_SRC-1:0]   match_me;
    logic [NUM_SRC*2-1:0] fwd_pre;
    logic                 hazard;
    logic                 mem_wait;

    hz_state_t            state_d, state_q;
    logic [NUM_SRC*2-1:0] fwd_sel_d, fwd_sel_q;
    logic [COUNT_W-1:0]   cnt_bubble_d, cnt_bubble_q;
    logic [COUNT_W-1:0]   cnt_memwait_d, cnt_memwait_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        src_match #(.REG_AW(REG_AW)) u_match (
            .rs       (rs_id[i*REG_AW +: REG_AW]),
            .rs_used  (rs_used_id[i]),
            .rd_ex    (rd_ex),
            .RUWr_ex  (RUWr_ex),
            .rd_me    (rd_me),
            .RUWr_me  (RUWr_me),
            .match_ex (match_ex[i]),
            .match_me (match_me[i])
        );
    end

    // EX producer is younger than ME producer, so it wins the select
    always_comb begin
        fwd_pre = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_pre[i*2 +: 2] = FWD_RF;
            if (FWD_ON) begin
                if (match_ex[i])      fwd_pre[i*2 +: 2] = FWD_ME;
                else if (match_me[i]) fwd_pre[i*2 +: 2] = FWD_WB;
            end
        end
    end

    always_comb begin
        mem_wait = mem_req_me && !dmem_ack;
        if (FWD_ON) hazard = is_load_ex && (|match_ex);
        else        hazard = (|match_ex) || (|match_me);

        stall_all = 1'b0;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_ex  = 1'b0;
        if (!rst) begin
            if (mem_wait) begin
                stall_all = 1'b1;
                stall_if  = 1'b1;
                stall_id  = 1'b1;
            end else if (hazard) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                flush_ex  = 1'b1;
            end
        end

        // Every state shares the same transition priority
        if (mem_wait)    state_d = MEM_WAIT;
        else if (hazard) state_d = BUBBLE;
        else             state_d = RUN;

        if (stall_all)     fwd_sel_d = fwd_sel_q;
        else if (flush_ex) fwd_sel_d = '0;
        else               fwd_sel_d = fwd_pre;

        cnt_bubble_d  = cnt_bubble_q;
        cnt_memwait_d = cnt_memwait_q;
        if (state_q == BUBBLE && cnt_bubble_q != '1)
            cnt_bubble_d = cnt_bubble_q + COUNT_W'(1);
        if (state_q == MEM_WAIT && cnt_memwait_q != '1)
            cnt_memwait_d = cnt_memwait_q + COUNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            fwd_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            fwd_sel_q <= fwd_sel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_bubble_q <= '0;
        else     cnt_bubble_q <= cnt_bubble_d;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_memwait_q <= '0;
        else     cnt_memwait_q <= cnt_memwait_d;
    end

    assign fwd_sel_ex  = fwd_sel_q;
    assign hz_state    = state_q;
    assign cnt_bubble  = cnt_bubble_q;
    assign cnt_memwait = cnt_memwait_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench: default controller, an interlocked (FWD_EN=0) copy and a
// 4-bit-counter copy, all driven from the same stimulus.
module tb_hazard_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] rs_id = '0;
    logic [1:0] rs_used_id = '0;
    logic [4:0] rd_ex = '0;
    logic       RUWr_ex = 1'b0;
    logic       is_load_ex = 1'b0;
    logic [4:0] rd_me = '0;
    logic       RUWr_me = 1'b0;
    logic       mem_req_me = 1'b0;
    logic       dmem_ack = 1'b0;

    logic [3:0]  d_fwd, n_fwd, s_fwd;
    logic        d_sif, d_sid, d_fl, d_sall;
    logic        n_sif, n_sid, n_fl, n_sall;
    logic        s_sif, s_sid, s_fl, s_sall;
    logic [1:0]  d_st, n_st, s_st;
    logic [31:0] d_cb, d_cm, n_cb, n_cm;
    logic [3:0]  s_cb, s_cm;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl u_dut (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rs_used_id(rs_used_id),
        .rd_ex(rd_ex), .RUWr_ex(RUWr_ex), .is_load_ex(is_load_ex),
        .rd_me(rd_me), .RUWr_me(RUWr_me), .mem_req_me(mem_req_me), .dmem_ack(dmem_ack),
        .fwd_sel_ex(d_fwd), .stall_if(d_sif), .stall_id(d_sid), .flush_ex(d_fl),
        .stall_all(d_sall), .hz_state(d_st), .cnt_bubble(d_cb), .cnt_memwait(d_cm)
    );

    hazard_forward_ctrl #(.FWD_EN(0)) u_nofwd (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rs_used_id(rs_used_id),
        .rd_ex(rd_ex), .RUWr_ex(RUWr_ex), .is_load_ex(is_load_ex),
        .rd_me(rd_me), .RUWr_me(RUWr_me), .mem_req_me(mem_req_me), .dmem_ack(dmem_ack),
        .fwd_sel_ex(n_fwd), .stall_if(n_sif), .stall_id(n_sid), .flush_ex(n_fl),
        .stall_all(n_sall), .hz_state(n_st), .cnt_bubble(n_cb), .cnt_memwait(n_cm)
    );

    hazard_forward_ctrl #(.COUNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rs_used_id(rs_used_id),
        .rd_ex(rd_ex), .RUWr_ex(RUWr_ex), .is_load_ex(is_load_ex),
        .rd_me(rd_me), .RUWr_me(RUWr_me), .mem_req_me(mem_req_me), .dmem_ack(dmem_ack),
        .fwd_sel_ex(s_fwd), .stall_if(s_sif), .stall_id(s_sid), .flush_ex(s_fl),
        .stall_all(s_sall), .hz_state(s_st), .cnt_bubble(s_cb), .cnt_memwait(s_cm)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_id = '0; rs_used_id = '0;
        rd_ex = '0; RUWr_ex = 1'b0; is_load_ex = 1'b0;
        rd_me = '0; RUWr_me = 1'b0;
        mem_req_me = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_fwd", d_fwd, 0);
        chk("rst_stall", {d_sall, d_sif, d_sid, d_fl}, 0);
        chk("rst_state", d_st, 0);
        chk("rst_cnt_b", d_cb, 0);
        chk("rst_cnt_m", d_cm, 0);

        // forward from EX producer on rs1
        rd_ex = 5; RUWr_ex = 1; rs_id = {5'd0, 5'd5}; rs_used_id = 2'b01;
        #1 chk("t1_nostall", {d_sif, d_sid, d_fl, d_sall}, 0);
        tick();
        chk("t1_fwd", d_fwd, 4'b0001);

        // EX and ME both write x5; rs2 reads x5
        rd_me = 5; RUWr_me = 1; rs_id = {5'd5, 5'd0}; rs_used_id = 2'b10;
        tick();
        chk("t2_ex_wins", d_fwd, 4'b0100);
        rd_ex = 0;
        tick();
        chk("t2_me_only", d_fwd, 4'b1000);
        rd_me = 0;
        tick();
        chk("t2_x0", d_fwd, 4'b0000);
        rs_used_id = 2'b00; rd_ex = 5; rd_me = 5;
        tick();
        chk("t2_unused", d_fwd, 4'b0000);

        // load-use: one bubble then WB forward
        do_reset();
        rd_ex = 7; RUWr_ex = 1; is_load_ex = 1; rs_id = {5'd0, 5'd7}; rs_used_id = 2'b01;
        #1 chk("t3_stall", {d_sall, d_sif, d_sid, d_fl}, 4'b0111);
        tick();
        chk("t3_state_b", d_st, 1);
        chk("t3_fwd_flush", d_fwd, 0);
        rd_ex = 0; RUWr_ex = 0; is_load_ex = 0; rd_me = 7; RUWr_me = 1;
        #1 chk("t3_release", {d_sall, d_sif, d_sid, d_fl}, 0);
        tick();
        chk("t3_fwd_wb", d_fwd, 4'b0010);
        chk("t3_state_run", d_st, 0);
        chk("t3_cnt_b", d_cb, 1);

        // memory wait with concurrent load-use
        do_reset();
        rd_me = 7; RUWr_me = 1; rs_id = {5'd0, 5'd7}; rs_used_id = 2'b01;
        tick();
        chk("t4_setup_fwd", d_fwd, 4'b0010);
        rd_me = 0; RUWr_me = 0; mem_req_me = 1; dmem_ack = 0;
        rd_ex = 7; RUWr_ex = 1; is_load_ex = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_stall_all", {d_sall, d_sif, d_sid, d_fl}, 4'b1110);
            tick();
            chk("t4_hold_fwd", d_fwd, 4'b0010);
            chk("t4_state_mw", d_st, 2);
        end
        dmem_ack = 1;
        #1 chk("t4_bubble", {d_sall, d_sif, d_sid, d_fl}, 4'b0111);
        tick();
        chk("t4_state_b", d_st, 1);
        chk("t4_fwd_flush", d_fwd, 0);
        chk("t4_cnt_m", d_cm, 3);
        rd_ex = 0; RUWr_ex = 0; is_load_ex = 0; rd_me = 7; RUWr_me = 1;
        mem_req_me = 0; dmem_ack = 0;
        #1 chk("t4_release", {d_sall, d_sif, d_sid, d_fl}, 0);
        tick();
        chk("t4_fwd_wb", d_fwd, 4'b0010);
        chk("t4_cnt_b", d_cb, 1);

        // ack without request, and zero-latency ack
        clear_inputs();
        dmem_ack = 1;
        #1 chk("ack_noreq", d_sall, 0);
        mem_req_me = 1;
        #1 chk("ack_zero_lat", {d_sall, d_sif}, 0);
        tick();
        chk("ack_state", d_st, 0);

        // interlocked build: EX dependency costs two bubbles
        do_reset();
        rd_ex = 3; RUWr_ex = 1; rs_id = {5'd0, 5'd3}; rs_used_id = 2'b01;
        #1 chk("t5_stall_ex", {n_sall, n_sif, n_sid, n_fl}, 4'b0111);
        chk("t5_fwd_nostall", {d_sif, d_fl}, 0);
        tick();
        chk("t5_state_b1", n_st, 1);
        chk("t5_fwd0_a", n_fwd, 0);
        chk("t5_dfwd", d_fwd, 4'b0001);
        rd_ex = 0; RUWr_ex = 0; rd_me = 3; RUWr_me = 1;
        #1 chk("t5_stall_me", {n_sid, n_fl}, 2'b11);
        tick();
        chk("t5_state_b2", n_st, 1);
        chk("t5_fwd0_b", n_fwd, 0);
        rd_me = 0; RUWr_me = 0;
        #1 chk("t5_release", {n_sall, n_sif, n_sid, n_fl}, 0);
        tick();
        chk("t5_state_run", n_st, 0);
        chk("t5_fwd0_c", n_fwd, 0);
        chk("t5_cnt_b", n_cb, 2);

        // saturation and reset out of MEM_WAIT
        do_reset();
        mem_req_me = 1; dmem_ack = 0;
        repeat (20) tick();
        chk("t6_sat", s_cm, 4'hf);
        chk("t6_cnt32", d_cm, 19);
        chk("t6_state_mw", d_st, 2);
        rst = 1;
        #1 chk("t6_rst_out", {d_sall, d_sif, d_sid, d_fl}, 0);
        tick();
        rst = 0; mem_req_me = 0;
        chk("t6_state_run", d_st, 0);
        chk("t6_cnt_clr", d_cm, 0);
        chk("t6_sat_clr", s_cm, 0);
        #1 chk("t6_out0", {d_sall, d_sif, d_sid, d_fl}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
